// File: rtl/linebuf_ctrl_if.sv
// Bundle of pixel input, line-FIFO and window-output signals for linebuf_ctrl.
// Handshake: in_valid is a one-way strobe with no ready. A pixel is consumed on
// every cycle where in_valid=1, frame_start=0, a frame is open and busy=0. Pixels
// offered while busy=1, outside a frame, or on a frame_start cycle are dropped.
// out_valid qualifies out_row0/1/2, out_col and out_row for exactly that cycle.
interface linebuf_ctrl_if #(
  parameter int DW = 8,
  parameter int CW = 10,
  parameter int RW = 9
);
  logic          frame_start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          lb0_wr_en;
  logic [DW-1:0] lb0_wr_data;
  logic          lb0_rd_en;
  logic [DW-1:0] lb0_rd_data;
  logic          lb1_wr_en;
  logic [DW-1:0] lb1_wr_data;
  logic          lb1_rd_en;
  logic [DW-1:0] lb1_rd_data;
  logic          out_valid;
  logic [DW-1:0] out_row0;
  logic [DW-1:0] out_row1;
  logic [DW-1:0] out_row2;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic          frame_done;
  logic          busy;

  // Pixel source, FIFO models and window consumer side
  modport master (
    output frame_start, in_valid, in_data, lb0_rd_data, lb1_rd_data,
    input  lb0_wr_en, lb0_wr_data, lb0_rd_en, lb1_wr_en, lb1_wr_data, lb1_rd_en,
    input  out_valid, out_row0, out_row1, out_row2, out_col, out_row,
    input  frame_done, busy
  );

  // Controller side
  modport slave (
    input  frame_start, in_valid, in_data, lb0_rd_data, lb1_rd_data,
    output lb0_wr_en, lb0_wr_data, lb0_rd_en, lb1_wr_en, lb1_wr_data, lb1_rd_en,
    output out_valid, out_row0, out_row1, out_row2, out_col, out_row,
    output frame_done, busy
  );
endinterface

// File: rtl/linebuf_ctrl.sv
// Two-line delay chain controller: drives lb0/lb1 so that each accepted pixel of
// row r emerges one cycle later together with rows r-1 and r-2 of the same column.
// Shadow counters mirror the four FIFO pointers so an aborted frame can be
// flushed back to pointer 0 before the next frame starts.
module linebuf_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  linebuf_ctrl_if.slave    bus,
  output logic [2:0]       o_dbg_state
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL0 = 3'd1,
    S_FILL1 = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_flush_go;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  // Shadow index: 0=lb0 wr, 1=lb0 rd, 2=lb1 wr, 3=lb1 rd
  logic [CW-1:0]         r_sh [4];
  logic [CW-1:0]         w_sh_nxt [4];
  logic                  r_lb1_wr_pend;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_row2;
  logic [CW-1:0]         r_out_col;
  logic [RW-1:0]         r_out_row;
  logic                  r_frame_done;

  logic       w_accept, w_in_frame, w_last_col, w_row_ge1, w_row_ge2;
  logic       w_flush_pulse, w_restart, w_clean;
  logic [3:0] w_en;

  assign w_in_frame    = (r_state == S_FILL0) || (r_state == S_FILL1) || (r_state == S_RUN);
  assign w_accept      = bus.in_valid && !bus.frame_start && w_in_frame;
  assign w_last_col    = (r_col == LAST_COL);
  assign w_row_ge1     = (r_row != '0);
  assign w_row_ge2     = (r_row > RW'(1));
  assign w_flush_pulse = (r_state == S_FLUSH) && r_flush_go;
  assign w_restart     = bus.frame_start && (r_state != S_FLUSH);

  // FIFO enables: pixel traffic, plus realignment pulses on non-zero pointers in FLUSH
  assign w_en[0] = w_accept                 || (w_flush_pulse && (r_sh[0] != '0));
  assign w_en[1] = (w_accept && w_row_ge1)  || (w_flush_pulse && (r_sh[1] != '0));
  assign w_en[2] = r_lb1_wr_pend            || (w_flush_pulse && (r_sh[2] != '0));
  assign w_en[3] = (w_accept && w_row_ge2)  || (w_flush_pulse && (r_sh[3] != '0));

  // Shadow pointer values after this cycle's enables; clean when all land on 0
  always_comb begin
    w_clean = !(w_accept && w_row_ge1);
    for (int k = 0; k < 4; k++) begin
      w_sh_nxt[k] = r_sh[k];
      if (w_en[k]) w_sh_nxt[k] = (r_sh[k] == LAST_COL) ? '0 : r_sh[k] + CW'(1);
      if (w_sh_nxt[k] != '0) w_clean = 1'b0;
    end
  end

  // Next-state logic; frame_start outside FLUSH restarts or flushes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL0: if (w_accept && w_last_col) w_state_nxt = S_FILL1;
      S_FILL1: if (w_accept && w_last_col) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last_col && (r_row == LAST_ROW)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_FLUSH: if (r_flush_go && w_clean) w_state_nxt = S_FILL0;
      default: w_state_nxt = r_state;
    endcase
    if (w_restart) w_state_nxt = w_clean ? S_FILL0 : S_FLUSH;
  end

  // State, flush pacing, position counters and shadow pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_flush_go    <= 1'b0;
      r_col         <= '0;
      r_row         <= '0;
      r_lb1_wr_pend <= 1'b0;
      for (int k = 0; k < 4; k++) r_sh[k] <= '0;
    end else begin
      r_state       <= w_state_nxt;
      // First FLUSH cycle only lets the last pending lb1 write land
      r_flush_go    <= (r_state == S_FLUSH) && (w_state_nxt == S_FLUSH);
      r_lb1_wr_pend <= w_accept && w_row_ge1;
      for (int k = 0; k < 4; k++) r_sh[k] <= w_sh_nxt[k];
      if (w_restart) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // Output stage: lines up the registered current pixel with FIFO read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_row2   <= '0;
      r_out_col    <= '0;
      r_out_row    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_accept && w_row_ge2;
      r_out_row2   <= bus.in_data;
      r_out_col    <= r_col;
      r_out_row    <= r_row;
      r_frame_done <= r_out_valid && (r_out_col == LAST_COL) && (r_out_row == LAST_ROW);
    end
  end

  assign bus.lb0_wr_en   = w_en[0];
  assign bus.lb0_wr_data = w_accept ? bus.in_data : '0;
  assign bus.lb0_rd_en   = w_en[1];
  assign bus.lb1_wr_en   = w_en[2];
  assign bus.lb1_wr_data = r_lb1_wr_pend ? bus.lb0_rd_data : '0;
  assign bus.lb1_rd_en   = w_en[3];
  assign bus.out_valid   = r_out_valid;
  assign bus.out_row2    = r_out_row2;
  assign bus.out_row1    = r_out_valid ? bus.lb0_rd_data : '0;
  assign bus.out_row0    = r_out_valid ? bus.lb1_rd_data : '0;
  assign bus.out_col     = r_out_col;
  assign bus.out_row     = r_out_row;
  assign bus.frame_done  = r_frame_done;
  assign bus.busy        = (r_state == S_FLUSH);
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_linebuf_ctrl.sv
// Bench for linebuf_ctrl with W=4, H=3 and two behavioural fifo_ram models.
module tb_linebuf_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int RW = 2;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         n_vec = 0;
  int         n_err = 0;

  linebuf_ctrl_if #(.DW(DW), .CW(CW), .RW(RW)) bus ();

  linebuf_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- line FIFO models (read-before-write, 1-cycle read) ----------------
  logic [DW-1:0] f0_mem [W];
  logic [DW-1:0] f1_mem [W];
  int f0_wp, f0_rp, f1_wp, f1_rp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f0_wp <= 0; f0_rp <= 0; bus.lb0_rd_data <= '0;
    end else begin
      if (bus.lb0_rd_en) begin
        bus.lb0_rd_data <= f0_mem[f0_rp];
        f0_rp <= (f0_rp + 1) % W;
      end
      if (bus.lb0_wr_en) begin
        f0_mem[f0_wp] <= bus.lb0_wr_data;
        f0_wp <= (f0_wp + 1) % W;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f1_wp <= 0; f1_rp <= 0; bus.lb1_rd_data <= '0;
    end else begin
      if (bus.lb1_rd_en) begin
        bus.lb1_rd_data <= f1_mem[f1_rp];
        f1_rp <= (f1_rp + 1) % W;
      end
      if (bus.lb1_wr_en) begin
        f1_mem[f1_wp] <= bus.lb1_wr_data;
        f1_wp <= (f1_wp + 1) % W;
      end
    end
  end

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame contents by (row, col); counts of accepted pixels give the FIFO pointer
  // positions, and an abort leaves (W - ptr) mod W realignment pulses per pointer.
  logic [DW-1:0] pix [H][W];
  bit  m_active, m_flush, m_wait;
  int  m_n;
  int  rem [4];
  bit  p_out, p_rd1, p_done;
  int  p_r, p_c;

  logic [23:0] obs_q [$];
  logic [23:0] exp_q [$];
  int busy_cnt, done_cnt;

  task automatic model_reset();
    m_active = 0; m_flush = 0; m_wait = 0; m_n = 0;
    for (int k = 0; k < 4; k++) rem[k] = 0;
    p_out = 0; p_rd1 = 0; p_done = 0; p_r = 0; p_c = 0;
  endtask

  initial model_reset();

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    bit acc, fp, e0, e1, e2, e3, all0;
    int r, c, n1, n2;
    #2;
    if (!rst_n) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_done", bus.frame_done, 0);
      chk("rst_lb0_wr_en", bus.lb0_wr_en, 0);
      chk("rst_lb1_wr_en", bus.lb1_wr_en, 0);
      model_reset();
    end else begin
      fp  = m_flush && !m_wait;
      acc = bus.in_valid && !bus.frame_start && m_active && !m_flush;
      r   = m_n / W;
      c   = m_n % W;
      e0  = acc || (fp && rem[0] > 0);
      e1  = (acc && r >= 1) || (fp && rem[1] > 0);
      e2  = p_rd1 || (fp && rem[2] > 0);
      e3  = (acc && r >= 2) || (fp && rem[3] > 0);
      if (bus.busy) busy_cnt++;
      if (bus.frame_done) done_cnt++;
      if (bus.out_valid) obs_q.push_back({bus.out_row0, bus.out_row1, bus.out_row2});

      chk("busy", bus.busy, m_flush);
      chk("lb0_wr_en", bus.lb0_wr_en, e0);
      chk("lb0_rd_en", bus.lb0_rd_en, e1);
      chk("lb1_wr_en", bus.lb1_wr_en, e2);
      chk("lb1_rd_en", bus.lb1_rd_en, e3);
      if (acc) chk("lb0_wr_data", bus.lb0_wr_data, bus.in_data);
      else if (e0) chk("lb0_flush_data", bus.lb0_wr_data, 0);
      if (p_rd1) chk("lb1_wr_data", bus.lb1_wr_data, pix[p_r-1][p_c]);
      else if (e2) chk("lb1_flush_data", bus.lb1_wr_data, 0);
      chk("out_valid", bus.out_valid, p_out);
      if (p_out) begin
        chk("out_row0", bus.out_row0, pix[p_r-2][p_c]);
        chk("out_row1", bus.out_row1, pix[p_r-1][p_c]);
        chk("out_row2", bus.out_row2, pix[p_r][p_c]);
        chk("out_col", bus.out_col, p_c);
        chk("out_row", bus.out_row, p_r);
      end
      chk("frame_done", bus.frame_done, p_done);

      // advance the model to the next cycle
      p_done = p_out && (p_c == W-1) && (p_r == H-1);
      p_out  = acc && (r >= 2);
      p_rd1  = acc && (r >= 1);
      p_r    = r;
      p_c    = c;
      if (acc) begin
        pix[r][c] = bus.in_data;
        m_n++;
        if (m_n == W*H) m_active = 0;
      end
      if (m_flush) begin
        if (m_wait) m_wait = 0;
        else begin
          all0 = 1;
          for (int k = 0; k < 4; k++) begin
            if (rem[k] > 0) rem[k]--;
            if (rem[k] != 0) all0 = 0;
          end
          if (all0) begin m_flush = 0; m_active = 1; m_n = 0; end
        end
      end else if (bus.frame_start) begin
        n1 = (m_n >= W)   ? m_n - W   : 0;
        n2 = (m_n >= 2*W) ? m_n - 2*W : 0;
        rem[0] = (W - m_n % W) % W;
        rem[1] = (W - n1 % W) % W;
        rem[2] = rem[1];
        rem[3] = (W - n2 % W) % W;
        if (rem[0] == 0 && rem[1] == 0 && rem[3] == 0) begin
          m_active = 1; m_n = 0;
        end else begin
          m_flush = 1; m_wait = 1; m_active = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic fs, input logic iv, input logic [DW-1:0] d);
    @(negedge clk);
    bus.frame_start = fs;
    bus.in_valid    = iv;
    bus.in_data     = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, DW'($urandom_range(0, 255)));
  endtask

  // mode 0: back-to-back, 1: alternate gaps, 2: random gaps
  task automatic send_pixels(input int base, input int mode);
    for (int i = 0; i < W*H; i++) begin
      step(0, 1, DW'(base + i));
      if (mode == 1) step(0, 0, 8'hEE);
      if (mode == 2) for (int g = $urandom_range(0, 2); g > 0; g--) step(0, 0, 8'hDD);
    end
  endtask

  // Pops four observed windows and compares them with the expected triples
  task automatic check_windows(input string name);
    logic [23:0] got;
    chk({name, "_count"}, (obs_q.size() >= 4) ? 4 : obs_q.size(), 4);
    while (exp_q.size() > 0) begin
      if (obs_q.size() > 0) got = obs_q.pop_front();
      else got = '1;
      chk(name, got, exp_q.pop_front());
    end
  endtask

  task automatic push_frame_windows(input int base);
    for (int k = 0; k < W; k++)
      exp_q.push_back({8'(base + k), 8'(base + W + k), 8'(base + 2*W + k)});
  endtask

  task automatic clear_obs();
    obs_q.delete(); busy_cnt = 0; done_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    busy_cnt = 0; done_cnt = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", dbg_state, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    #3 rst_n = 1'b1;
    idle(2);

    // 1: one frame back-to-back, hand-computed windows
    clear_obs();
    step(1, 0, 0);
    send_pixels(1, 0);
    idle(4);
    exp_q = '{24'h010509, 24'h02060A, 24'h03070B, 24'h04080C};
    check_windows("t1_window");
    chk("t1_frame_done", done_cnt, 1);
    chk("t1_busy", busy_cnt, 0);

    // 2: same frame with alternating in_valid
    clear_obs();
    step(1, 0, 0);
    send_pixels(1, 1);
    idle(4);
    push_frame_windows(1);
    check_windows("t2_window");
    chk("t2_frame_done", done_cnt, 1);

    // 3: pixels outside a frame and on the frame_start cycle are dropped
    clear_obs();
    for (int i = 0; i < 3; i++) step(0, 1, 8'd50);
    step(1, 1, 8'd99);
    send_pixels(1, 0);
    idle(4);
    push_frame_windows(1);
    check_windows("t3_window");

    // 4: abort after 6 pixels, flush, then a clean frame
    clear_obs();
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, DW'(i + 1));
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hAA);
    send_pixels(1, 0);
    idle(4);
    chk("t4_busy_cycles", busy_cnt, 3);
    push_frame_windows(1);
    check_windows("t4_window");

    // 5: back-to-back frames, second frame_start right after the last pixel
    clear_obs();
    step(1, 0, 0);
    send_pixels(1, 0);
    step(1, 0, 0);
    send_pixels(101, 0);
    idle(4);
    chk("t5_busy", busy_cnt, 0);
    chk("t5_frame_done", done_cnt, 2);
    push_frame_windows(1);
    check_windows("t5_win_f1");
    push_frame_windows(101);
    check_windows("t5_win_f2");

    // random traffic: frames, aborts, stalls and frame_starts while busy
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0),
           DW'($urandom_range(0, 255)));
    end
    idle(3);
    step(1, 0, 0);
    for (int i = 0; i < 40; i++) step(0, ($urandom_range(0, 3) != 0), DW'($urandom_range(0, 255)));
    idle(4);
    for (int i = 0; i < 20 && bus.busy; i++) idle(1);
    chk("rand_busy_cleared", bus.busy, 0);

    // 6: asynchronous reset in the middle of RUN
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, DW'(i + 1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_state", dbg_state, 0);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_lb0_wr_en", bus.lb0_wr_en, 0);
    chk("t6_lb0_wr_data", bus.lb0_wr_data, 0);
    chk("t6_busy", bus.busy, 0);
    idle(2);
    @(negedge clk);
    #4 rst_n = 1'b1;
    idle(1);
    clear_obs();
    step(1, 0, 0);
    send_pixels(1, 0);
    idle(4);
    chk("t6_busy_after", busy_cnt, 0);
    push_frame_windows(1);
    check_windows("t6_window");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end
endmodule
